aliens_ctrl_latch: RTL and testbench

- Control-register stage directly downstream of the address-decode PAL.
- Consumes the PAL's active-low control-region select and the CPU bus.
- Produces the signals the decoder and board consume: BK4 (bank/palette select), WOCO (work/colour RAM select), INIT (watchdog-driven CPU init), ROM bank bits, coin-counter pulses and the sound-command latch with IRQ handshake.

---
 rtl/aliens_ctrl_latch.sv | 196 +++++++++++++++++++
 tb/tb_aliens_ctrl_latch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aliens_ctrl_latch.sv
// Control-register stage behind the address-decode PAL: bank/colour selects,
// ROM bank, coin-counter pulses, sound command latch and watchdog-driven INIT.
module aliens_ctrl_latch #(
    parameter int unsigned COIN_PULSE  = 2048,
    parameter int unsigned WDOG_CYCLES = 1048576,
    parameter int unsigned INIT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ctrl_cs_n,
    input  logic       cpu_rnw,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_dout,
    output logic [7:0] cpu_din,
    input  logic       snd_ack,
    output logic       bk4,
    output logic       woco,
    output logic       init,
    output logic [4:0] rom_bank,
    output logic [1:0] coin_ctr,
    output logic [7:0] snd_cmd,
    output logic       snd_irq
);

    localparam int unsigned CoinW = $clog2(COIN_PULSE + 1);
    localparam int unsigned WdogW = $clog2(WDOG_CYCLES);
    localparam int unsigned InitW = $clog2(INIT_CYCLES);

    localparam logic [CoinW-1:0] CoinLoad = CoinW'(COIN_PULSE);
    localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);
    localparam logic [InitW-1:0] InitLast = InitW'(INIT_CYCLES - 1);

    localparam logic [0:0] StRun  = 1'b0;
    localparam logic [0:0] StInit = 1'b1;

    logic                  cs_q;
    logic [0:0]            state_q, state_d;
    logic [WdogW-1:0]      wdog_q, wdog_d;
    logic [InitW-1:0]      icnt_q, icnt_d;
    logic                  bk4_q, bk4_d;
    logic                  woco_q, woco_d;
    logic [4:0]            bank_q, bank_d;
    logic [1:0]            req_q, req_d;
    logic [7:0]            cmd_q, cmd_d;
    logic                  irq_q, irq_d;
    logic [7:0]            din_q, din_d;
    logic [1:0][CoinW-1:0] coin_q, coin_d;

    logic strobe, wr, rd, in_init, force_rst;
    logic [1:0] rise;

    // One access per falling edge of the select, however long it stays low.
    assign strobe  = ~ctrl_cs_n & cs_q;
    assign wr      = strobe & ~cpu_rnw;
    assign rd      = strobe & cpu_rnw;
    assign in_init = (state_q == StInit);

    // Watchdog / INIT sequencing; a kick takes priority over terminal count.
    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        icnt_d  = icnt_q;
        unique case (state_q)
            StRun: begin
                if (wr && cpu_addr == 2'd2) begin
                    wdog_d = '0;
                end else if (wdog_q == WdogLast) begin
                    state_d = StInit;
                    wdog_d  = '0;
                    icnt_d  = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StInit: begin
                wdog_d = '0;
                if (icnt_q == InitLast) begin
                    state_d = StRun;
                    icnt_d  = '0;
                end else begin
                    icnt_d = icnt_q + 1'b1;
                end
            end
        endcase
    end

    // Register writes, sound handshake, coin pulse counters and read data.
    always_comb begin
        bk4_d  = bk4_q;
        woco_d = woco_q;
        bank_d = bank_q;
        req_d  = req_q;
        cmd_d  = cmd_q;
        irq_d  = irq_q;
        din_d  = din_q;
        coin_d = coin_q;
        // Clear on INIT entry too, so state and outputs change on the same edge.
        force_rst = in_init || (state_d == StInit);

        if (force_rst) begin
            bk4_d  = 1'b0;
            woco_d = 1'b0;
            bank_d = '0;
            req_d  = '0;
            cmd_d  = '0;
            irq_d  = 1'b0;
        end else begin
            if (snd_ack) irq_d = 1'b0;
            if (wr) begin
                unique case (cpu_addr)
                    2'd0: begin
                        req_d  = cpu_dout[1:0];
                        woco_d = cpu_dout[5];
                        bk4_d  = cpu_dout[6];
                    end
                    2'd1: begin
                        cmd_d = cpu_dout;
                        irq_d = 1'b1;
                    end
                    2'd2: ;
                    2'd3: bank_d = cpu_dout[4:0];
                endcase
            end
        end

        rise = req_d & ~req_q;
        for (int i = 0; i < 2; i++) begin
            if (force_rst) begin
                coin_d[i] = '0;
            end else if (coin_q[i] != '0) begin
                coin_d[i] = coin_q[i] - 1'b1;
            end else if (rise[i]) begin
                coin_d[i] = CoinLoad;
            end
        end

        if (rd) begin
            if (in_init) begin
                din_d = 8'h00;
            end else begin
                unique case (cpu_addr)
                    2'd0: din_d = {1'b0, bk4_q, woco_q, 3'b000, req_q};
                    2'd1: din_d = cmd_q;
                    2'd2: din_d = 8'h00;
                    2'd3: din_d = {3'b000, bank_q};
                endcase
            end
        end
    end

    // State registers with synchronous active-low reset into INIT.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cs_q    <= 1'b1;
            state_q <= StInit;
            wdog_q  <= '0;
            icnt_q  <= '0;
            bk4_q   <= 1'b0;
            woco_q  <= 1'b0;
            bank_q  <= '0;
            req_q   <= '0;
            cmd_q   <= '0;
            irq_q   <= 1'b0;
            din_q   <= '0;
            coin_q  <= '0;
        end else begin
            cs_q    <= ctrl_cs_n;
            state_q <= state_d;
            wdog_q  <= wdog_d;
            icnt_q  <= icnt_d;
            bk4_q   <= bk4_d;
            woco_q  <= woco_d;
            bank_q  <= bank_d;
            req_q   <= req_d;
            cmd_q   <= cmd_d;
            irq_q   <= irq_d;
            din_q   <= din_d;
            coin_q  <= coin_d;
        end
    end

    // Output drive; coin lines are high while their counter is running.
    always_comb begin
        coin_ctr = 2'b00;
        for (int i = 0; i < 2; i++) coin_ctr[i] = (coin_q[i] != '0);
    end

    assign cpu_din  = din_q;
    assign bk4      = bk4_q;
    assign woco     = woco_q;
    assign init     = in_init;
    assign rom_bank = bank_q;
    assign snd_cmd  = cmd_q;
    assign snd_irq  = irq_q;

endmodule

// File: tb/tb_aliens_ctrl_latch.sv
// Scoreboard bench for aliens_ctrl_latch: the stimulus process schedules
// expected output values per clock cycle; the monitor checks them on negedge.
module tb_aliens_ctrl_latch;

    localparam int SigDin  = 0;
    localparam int SigBk4  = 1;
    localparam int SigWoco = 2;
    localparam int SigInit = 3;
    localparam int SigBank = 4;
    localparam int SigCoin = 5;
    localparam int SigCmd  = 6;
    localparam int SigIrq  = 7;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ctrl_cs_n;
    logic       cpu_rnw;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_dout;
    logic [7:0] cpu_din;
    logic       snd_ack;
    logic       bk4, woco, init, snd_irq;
    logic [4:0] rom_bank;
    logic [1:0] coin_ctr;
    logic [7:0] snd_cmd;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    aliens_ctrl_latch #(
        .COIN_PULSE (8),
        .WDOG_CYCLES(16),
        .INIT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ctrl_cs_n(ctrl_cs_n),
        .cpu_rnw  (cpu_rnw),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_din  (cpu_din),
        .snd_ack  (snd_ack),
        .bk4      (bk4),
        .woco     (woco),
        .init     (init),
        .rom_bank (rom_bank),
        .coin_ctr (coin_ctr),
        .snd_cmd  (snd_cmd),
        .snd_irq  (snd_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(int sig);
        case (sig)
            SigDin:  return cpu_din;
            SigBk4:  return {7'b0, bk4};
            SigWoco: return {7'b0, woco};
            SigInit: return {7'b0, init};
            SigBank: return {3'b0, rom_bank};
            SigCoin: return {6'b0, coin_ctr};
            SigCmd:  return snd_cmd;
            default: return {7'b0, snd_irq};
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle; late ones count as failures.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [7:0] a;
                a = actual(sb[i].sig);
                checks++;
                if (sb[i].cyc != cyc || a !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got %h, expected %h (due cyc %0d)",
                             sb[i].name, cyc, a, sb[i].val, sb[i].cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(int d, int sig, logic [7:0] v, string nm);
        exp_t e;
        e.cyc  = cyc + d;
        e.sig  = sig;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Single-cycle select access; returns just after the edge where it takes effect.
    task automatic bus(logic rnw, logic [1:0] a, logic [7:0] d, logic ack);
        @(posedge clk); #1;
        ctrl_cs_n = 1'b0;
        cpu_rnw   = rnw;
        cpu_addr  = a;
        cpu_dout  = d;
        snd_ack   = ack;
        @(posedge clk); #1;
        ctrl_cs_n = 1'b1;
        cpu_rnw   = 1'b1;
        snd_ack   = 1'b0;
    endtask

    task automatic wr(logic [1:0] a, logic [7:0] d);
        bus(1'b0, a, d, 1'b0);
    endtask

    task automatic rd(logic [1:0] a);
        bus(1'b1, a, 8'h00, 1'b0);
    endtask

    task automatic kick();
        wr(2'd2, 8'h00);
    endtask

    initial begin
        reset_n   = 1'b0;
        ctrl_cs_n = 1'b1;
        cpu_rnw   = 1'b1;
        cpu_addr  = 2'd0;
        cpu_dout  = 8'h00;
        snd_ack   = 1'b0;

        // Reset for 3 edges, then init stays high for 4 cycles.
        repeat (3) @(posedge clk);
        #1;
        expect_at(0, SigDin, 8'h00, "rst_din");
        expect_at(0, SigBk4, 8'h00, "rst_bk4");
        expect_at(0, SigWoco, 8'h00, "rst_woco");
        expect_at(0, SigBank, 8'h00, "rst_bank");
        expect_at(0, SigCoin, 8'h00, "rst_coin");
        expect_at(0, SigCmd, 8'h00, "rst_cmd");
        expect_at(0, SigIrq, 8'h00, "rst_irq");
        for (int d = 0; d < 4; d++) expect_at(d, SigInit, 8'h01, "rst_init_hi");
        expect_at(4, SigInit, 8'h00, "rst_init_lo");
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Bank write and readback.
        wr(2'd3, 8'hFF);
        expect_at(0, SigBank, 8'h1F, "bank_ff");
        rd(2'd3);
        expect_at(0, SigDin, 8'h1F, "rd_bank");
        expect_at(2, SigDin, 8'h1F, "rd_hold");
        kick();

        // CTRL: bk4/woco and coin 0 pulse; rewrite mid-pulse must not extend it.
        wr(2'd0, 8'h61);
        expect_at(0, SigWoco, 8'h01, "ctrl_woco");
        expect_at(0, SigBk4, 8'h01, "ctrl_bk4");
        expect_at(0, SigCoin, 8'h01, "coin0_start");
        expect_at(7, SigCoin, 8'h01, "coin0_last");
        wr(2'd0, 8'h61);
        rd(2'd0);
        expect_at(0, SigDin, 8'h61, "rd_ctrl");
        kick();
        wr(2'd0, 8'h62);
        expect_at(0, SigCoin, 8'h02, "coin0_end_coin1_start");
        expect_at(7, SigCoin, 8'h02, "coin1_last");
        expect_at(8, SigCoin, 8'h00, "coin1_end");

        // Sound command handshake.
        wr(2'd1, 8'h5A);
        expect_at(0, SigCmd, 8'h5A, "snd_cmd_5a");
        expect_at(0, SigIrq, 8'h01, "snd_irq_set");
        @(posedge clk); #1 snd_ack = 1'b1;
        @(posedge clk); #1 snd_ack = 1'b0;
        expect_at(0, SigIrq, 8'h00, "snd_ack_clr");
        bus(1'b0, 2'd1, 8'hA5, 1'b1);
        expect_at(0, SigIrq, 8'h01, "snd_wr_wins");
        expect_at(0, SigCmd, 8'hA5, "snd_cmd_a5");
        expect_at(1, SigIrq, 8'h01, "snd_irq_hold");
        kick();

        // Select held low 10 cycles: exactly one write, so the ack is not undone.
        @(posedge clk); #1;
        ctrl_cs_n = 1'b0;
        cpu_rnw   = 1'b0;
        cpu_addr  = 2'd1;
        cpu_dout  = 8'h3C;
        expect_at(1, SigCmd, 8'h3C, "held_cmd");
        expect_at(1, SigIrq, 8'h01, "held_irq");
        repeat (3) @(posedge clk);
        #1 snd_ack = 1'b1;
        @(posedge clk); #1 snd_ack = 1'b0;
        expect_at(0, SigIrq, 8'h00, "held_ack");
        expect_at(6, SigIrq, 8'h00, "held_single");
        repeat (6) @(posedge clk);
        #1;
        ctrl_cs_n = 1'b1;
        cpu_rnw   = 1'b1;

        // Regular kicks keep init low.
        kick();
        for (int k = 0; k < 3; k++) begin
            repeat (8) @(posedge clk);
            #1;
            expect_at(0, SigInit, 8'h00, "wdog_kicked");
            kick();
        end

        // Stop kicking: init 16 cycles after the last kick, for 4 cycles.
        wr(2'd3, 8'h0A);
        expect_at(0, SigBank, 8'h0A, "bank_0a");
        wr(2'd0, 8'h40);
        expect_at(0, SigBk4, 8'h01, "bk4_set");
        expect_at(0, SigCoin, 8'h00, "no_coin");
        expect_at(11, SigInit, 8'h00, "wdog_pre");
        expect_at(12, SigInit, 8'h01, "wdog_fire");
        expect_at(12, SigBank, 8'h00, "wdog_bank_clr");
        expect_at(12, SigBk4, 8'h00, "wdog_bk4_clr");
        expect_at(15, SigInit, 8'h01, "wdog_init_last");
        expect_at(16, SigInit, 8'h00, "wdog_init_end");
        repeat (11) @(posedge clk);
        #1;
        wr(2'd3, 8'h15);
        expect_at(0, SigBank, 8'h00, "init_wr_ignored");
        expect_at(1, SigBank, 8'h00, "init_wr_ignored2");
        rd(2'd3);
        expect_at(0, SigDin, 8'h00, "init_rd_zero");

        // Reset mid coin pulse with snd_irq set.
        wr(2'd0, 8'h01);
        expect_at(0, SigCoin, 8'h01, "coin0_again");
        wr(2'd1, 8'h77);
        expect_at(0, SigIrq, 8'h01, "irq_before_rst");
        expect_at(0, SigCmd, 8'h77, "cmd_before_rst");
        expect_at(1, SigCoin, 8'h01, "coin_before_rst");
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        expect_at(0, SigCoin, 8'h00, "mrst_coin");
        expect_at(0, SigIrq, 8'h00, "mrst_irq");
        expect_at(0, SigCmd, 8'h00, "mrst_cmd");
        expect_at(0, SigDin, 8'h00, "mrst_din");
        expect_at(0, SigInit, 8'h01, "mrst_init");
        expect_at(2, SigCoin, 8'h00, "mrst_coin_stays");
        expect_at(3, SigInit, 8'h01, "mrst_init_last");
        expect_at(4, SigInit, 8'h00, "mrst_init_end");

        repeat (8) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            errors += sb.size();
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
